hwag_core: RTL and testbench

- Hardware angle generator front end for a 60-2 crank trigger wheel.
- Measures the period between crank tooth edges on `cap` and detects the missing-tooth gap.
- Counts teeth, qualifies synchronisation over a full revolution and uses `cam` to pick the engine cycle phase.
- Flags `second_edge` once a valid tooth period exists, and `hwag_start` once crank and cam sync are both established; downstream angle and ignition logic starts from `hwag_start`.

---
 rtl/hwag_core.sv | 145 ++++++++++++++
 tb/tb_hwag_core.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_core.sv
// Crank/cam front end for a 60-2 trigger wheel: tooth period capture, missing-tooth
// gap detection, revolution qualification and cam phase search, ending in hwag_start.
module hwag_core #(
   parameter int TIMER_W = 24,
   parameter int TEETH   = 58,
   parameter int GAP_NUM = 3,
   parameter int GAP_DEN = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic cap,
   input  logic cam,
   output logic second_edge,
   output logic hwag_start
);

   // state      | meaning
   // IDLE       | no tooth seen since reset or stall
   // MEASURE    | first tooth seen, waiting for a valid period
   // SEARCH     | periods valid, hunting for the missing-tooth gap
   // CHECK      | gap found, confirming the next gap lands a full revolution later
   // CRANK_SYNC | crank position qualified, waiting for a gap with cam low
   // SYNCED     | crank and cam phase locked, hwag_start asserted
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      MEASURE    = 3'd1,
      SEARCH     = 3'd2,
      CHECK      = 3'd3,
      CRANK_SYNC = 3'd4,
      SYNCED     = 3'd5
   } state_t;

   localparam int MW = TIMER_W + 8;
   localparam logic [TIMER_W-1:0] T_MAX = '1;
   localparam logic [5:0] LAST_TOOTH = 6'(TEETH - 1);

   state_t state, state_nxt;

   logic cap_s1, cap_s2, cap_s3;
   logic cam_s1, cam_s2;
   logic tooth, stall, timer_sat, gap, gap_pos_ok;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] cur_period;
   logic [TIMER_W:0]   timer_inc;
   logic [TIMER_W-1:0] cur_next;
   logic [MW-1:0]      lhs, rhs;
   logic [5:0]         tooth_cnt;
   logic [1:0]         edge_cnt, edge_cnt_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_s1 <= 1'b0;
         cap_s2 <= 1'b0;
         cap_s3 <= 1'b0;
         cam_s1 <= 1'b0;
         cam_s2 <= 1'b0;
      end else begin
         cap_s1 <= cap;
         cap_s2 <= cap_s1;
         cap_s3 <= cap_s2;
         cam_s1 <= cam;
         cam_s2 <= cam_s1;
      end
   end

   assign tooth     = cap_s2 & ~cap_s3;
   assign timer_sat = (timer == T_MAX);
   assign stall     = timer_sat & ~tooth;
   assign timer_inc = {1'b0, timer} + {{TIMER_W{1'b0}}, 1'b1};
   // A period longer than the timer range is pinned at full scale instead of wrapping small.
   assign cur_next  = timer_sat ? T_MAX : timer_inc[TIMER_W-1:0];

   // cur_period still holds the previous period at the moment a new tooth is compared.
   assign lhs        = MW'(timer_inc) * MW'(GAP_DEN);
   assign rhs        = MW'(cur_period) * MW'(GAP_NUM);
   assign gap        = tooth & (edge_cnt == 2'd2) & (lhs > rhs);
   assign gap_pos_ok = (tooth_cnt == LAST_TOOTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer      <= '0;
         cur_period <= '0;
         tooth_cnt  <= '0;
      end else begin
         if (tooth) begin
            timer      <= '0;
            cur_period <= cur_next;
         end else if (!timer_sat) begin
            timer <= timer_inc[TIMER_W-1:0];
         end
         if (gap)
            tooth_cnt <= '0;
         else if (tooth && (tooth_cnt != 6'h3f))
            tooth_cnt <= tooth_cnt + 6'd1;
      end
   end

   always_comb begin
      state_nxt    = state;
      edge_cnt_nxt = edge_cnt;
      if (state == IDLE)
         edge_cnt_nxt = tooth ? 2'd1 : 2'd0;
      else if (tooth && (edge_cnt != 2'd2))
         edge_cnt_nxt = edge_cnt + 2'd1;

      case (state)
         IDLE:    if (tooth) state_nxt = MEASURE;
         MEASURE: if (second_edge) state_nxt = SEARCH;
         SEARCH:  if (gap) state_nxt = CHECK;
         CHECK, CRANK_SYNC, SYNCED: begin
            if (gap) begin
               if (!gap_pos_ok)
                  state_nxt = SEARCH;
               else if (state == CHECK)
                  state_nxt = CRANK_SYNC;
               else if (state == CRANK_SYNC && !cam_s2)
                  state_nxt = SYNCED;
            end else if (tooth && gap_pos_ok) begin
               state_nxt = SEARCH;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (stall) begin
         state_nxt    = IDLE;
         edge_cnt_nxt = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         edge_cnt    <= 2'd0;
         second_edge <= 1'b0;
         hwag_start  <= 1'b0;
      end else begin
         state       <= state_nxt;
         edge_cnt    <= edge_cnt_nxt;
         second_edge <= (edge_cnt_nxt == 2'd2);
         hwag_start  <= (state_nxt == SYNCED);
      end
   end

endmodule

// File: tb/tb_hwag_core.sv
// Directed bench for hwag_core with a shortened timer and a scaled-down tooth period.
module tb_hwag_core;

   localparam int TW = 12;
   localparam int P  = 40;
   localparam logic [2:0] S_IDLE = 3'd0, S_MEASURE = 3'd1, S_SEARCH = 3'd2,
                          S_CHECK = 3'd3, S_CRANK = 3'd4, S_SYNCED = 3'd5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cap = 1'b0;
   logic cam = 1'b1;
   logic second_edge, hwag_start;
   int checks = 0;
   int failures = 0;

   hwag_core #(.TIMER_W(TW)) dut (
      .clk(clk), .rst(rst), .cap(cap), .cam(cam),
      .second_edge(second_edge), .hwag_start(hwag_start)
   );

   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Rising edge lands p clocks after the previous one; returns once the tooth has registered.
   task automatic pulse(input int p);
      cap = 1'b0;
      repeat (p - 3) @(negedge clk);
      cap = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic normals(input int n, input int p);
      for (int i = 0; i < n; i++) pulse(p);
   endtask

   task automatic gap_edge(input int p, input logic cam_lvl);
      cam = cam_lvl;
      pulse(3 * p);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cap = ~cap;
         repeat (2) @(negedge clk);
      end
      checks++;
      if (second_edge !== 1'b0 || hwag_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_out: got se=%b hs=%b want 0 0", second_edge, hwag_start);
      end
      checks++;
      if (dut.state !== S_IDLE) begin
         failures++;
         $display("FAIL reset_state: got %0d want %0d", dut.state, S_IDLE);
      end
      cap = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (second_edge !== 1'b0 || hwag_start !== 1'b0 || dut.state !== S_IDLE) begin
         failures++;
         $display("FAIL post_reset: got se=%b hs=%b st=%0d want 0 0 0", second_edge, hwag_start, dut.state);
      end
   endtask

   task automatic test_period_capture;
      pulse(P);
      checks++;
      if (second_edge !== 1'b0 || dut.state !== S_MEASURE) begin
         failures++;
         $display("FAIL first_edge: got se=%b st=%0d want 0 %0d", second_edge, dut.state, S_MEASURE);
      end
      pulse(P);
      checks++;
      if (second_edge !== 1'b1) begin
         failures++;
         $display("FAIL second_edge: got %b want 1", second_edge);
      end
      checks++;
      if (dut.cur_period !== 12'(P)) begin
         failures++;
         $display("FAIL cur_period: got %0d want %0d", dut.cur_period, P);
      end
      pulse(P);
      checks++;
      if (dut.state !== S_SEARCH) begin
         failures++;
         $display("FAIL search_entry: got %0d want %0d", dut.state, S_SEARCH);
      end
   endtask

   task automatic test_gap_detect;
      cam = 1'b1;
      normals(55, P);
      checks++;
      if (dut.state !== S_SEARCH) begin
         failures++;
         $display("FAIL no_false_gap: got %0d want %0d", dut.state, S_SEARCH);
      end
      gap_edge(P, 1'b1);
      checks++;
      if (dut.state !== S_CHECK || dut.tooth_cnt !== 6'd0) begin
         failures++;
         $display("FAIL gap1: got st=%0d tooth=%0d want %0d 0", dut.state, dut.tooth_cnt, S_CHECK);
      end
      normals(57, P);
      checks++;
      if (dut.tooth_cnt !== 6'd57 || dut.state !== S_CHECK) begin
         failures++;
         $display("FAIL rev_count: got tooth=%0d st=%0d want 57 %0d", dut.tooth_cnt, dut.state, S_CHECK);
      end
      gap_edge(P, 1'b1);
      checks++;
      if (dut.state !== S_CRANK || hwag_start !== 1'b0) begin
         failures++;
         $display("FAIL gap2: got st=%0d hs=%b want %0d 0", dut.state, hwag_start, S_CRANK);
      end
      normals(57, P);
      gap_edge(P, 1'b1);
      checks++;
      if (dut.state !== S_CRANK || hwag_start !== 1'b0) begin
         failures++;
         $display("FAIL cam_high_gap: got st=%0d hs=%b want %0d 0", dut.state, hwag_start, S_CRANK);
      end
   endtask

   task automatic test_cam_phase;
      normals(57, P);
      cam = 1'b0;
      cap = 1'b0;
      repeat (3 * P - 3) @(negedge clk);
      cap = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (hwag_start !== 1'b0) begin
         failures++;
         $display("FAIL hs_early: got %b want 0", hwag_start);
      end
      @(negedge clk);
      checks++;
      if (hwag_start !== 1'b1 || dut.state !== S_SYNCED) begin
         failures++;
         $display("FAIL hs_rise: got hs=%b st=%0d want 1 %0d", hwag_start, dut.state, S_SYNCED);
      end
      normals(57, P);
      gap_edge(P, 1'b1);
      checks++;
      if (hwag_start !== 1'b1) begin
         failures++;
         $display("FAIL hs_hold_cam1: got %b want 1", hwag_start);
      end
      normals(57, P);
      gap_edge(P, 1'b0);
      checks++;
      if (hwag_start !== 1'b1) begin
         failures++;
         $display("FAIL hs_hold_cam0: got %b want 1", hwag_start);
      end
   endtask

   task automatic test_sync_loss;
      normals(29, P);
      cap = 1'b0;
      repeat (3 * P - 3) @(negedge clk);
      cap = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (hwag_start !== 1'b1) begin
         failures++;
         $display("FAIL loss_early: got %b want 1", hwag_start);
      end
      @(negedge clk);
      checks++;
      if (hwag_start !== 1'b0 || dut.state !== S_SEARCH) begin
         failures++;
         $display("FAIL loss_drop: got hs=%b st=%0d want 0 %0d", hwag_start, dut.state, S_SEARCH);
      end
      normals(27, P);
      gap_edge(P, 1'b0);
      checks++;
      if (dut.state !== S_CHECK || hwag_start !== 1'b0) begin
         failures++;
         $display("FAIL resync_gap1: got st=%0d hs=%b want %0d 0", dut.state, hwag_start, S_CHECK);
      end
      normals(57, P);
      gap_edge(P, 1'b0);
      checks++;
      if (dut.state !== S_CRANK || hwag_start !== 1'b0) begin
         failures++;
         $display("FAIL resync_gap2: got st=%0d hs=%b want %0d 0", dut.state, hwag_start, S_CRANK);
      end
      normals(57, P);
      gap_edge(P, 1'b0);
      checks++;
      if (dut.state !== S_SYNCED || hwag_start !== 1'b1) begin
         failures++;
         $display("FAIL resync_gap3: got st=%0d hs=%b want %0d 1", dut.state, hwag_start, S_SYNCED);
      end
   endtask

   task automatic test_stall;
      cap = 1'b0;
      repeat ((1 << TW) - 1) @(negedge clk);
      checks++;
      if (hwag_start !== 1'b1 || second_edge !== 1'b1) begin
         failures++;
         $display("FAIL pre_stall: got hs=%b se=%b want 1 1", hwag_start, second_edge);
      end
      @(negedge clk);
      checks++;
      if (hwag_start !== 1'b0 || second_edge !== 1'b0 || dut.state !== S_IDLE) begin
         failures++;
         $display("FAIL stall: got hs=%b se=%b st=%0d want 0 0 %0d", hwag_start, second_edge, dut.state, S_IDLE);
      end
      pulse(P);
      pulse(1 << TW);
      checks++;
      if (second_edge !== 1'b1 || dut.state !== S_MEASURE) begin
         failures++;
         $display("FAIL tooth_beats_sat: got se=%b st=%0d want 1 %0d", second_edge, dut.state, S_MEASURE);
      end
   endtask

   task automatic test_acceleration;
      int p;
      logic [2:0] want [4];
      logic cam_at [4];
      want[0] = S_CHECK;  cam_at[0] = 1'b1;
      want[1] = S_CRANK;  cam_at[1] = 1'b1;
      want[2] = S_SYNCED; cam_at[2] = 1'b0;
      want[3] = S_SYNCED; cam_at[3] = 1'b1;
      p = 64;
      for (int r = 0; r < 4; r++) begin
         normals(57, p);
         if (r > 0) begin
            checks++;
            if (dut.tooth_cnt !== 6'd57) begin
               failures++;
               $display("FAIL accel_tooth r%0d: got %0d want 57", r, dut.tooth_cnt);
            end
         end
         gap_edge(p, cam_at[r]);
         checks++;
         if (dut.state !== want[r]) begin
            failures++;
            $display("FAIL accel_state r%0d: got %0d want %0d", r, dut.state, want[r]);
         end
         p = p - p / 32;
      end
      checks++;
      if (hwag_start !== 1'b1) begin
         failures++;
         $display("FAIL accel_hs: got %b want 1", hwag_start);
      end
   endtask

   task automatic test_missing_gap;
      normals(57, 59);
      pulse(59);
      checks++;
      if (hwag_start !== 1'b0 || dut.state !== S_SEARCH) begin
         failures++;
         $display("FAIL missing_gap: got hs=%b st=%0d want 0 %0d", hwag_start, dut.state, S_SEARCH);
      end
   endtask

   initial begin
      test_reset;
      test_period_capture;
      test_gap_detect;
      test_cam_phase;
      test_sync_loss;
      test_stall;
      test_acceleration;
      test_missing_gap;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
